// File: rtl/eth_param_pkg.sv
// Shared constants and types for the Ethernet parameter loader.
package eth_param_pkg;

    // Command opcodes
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_COMMIT = 4'h2;
    localparam logic [3:0] OP_CLEAR  = 4'h3;

    // Field positions inside the 32-bit command word
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned SEQ_MSB  = 27;
    localparam int unsigned SEQ_LSB  = 24;
    localparam int unsigned ADDR_MSB = 23;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic {IDLE, ARMED} commit_state_t;

    // Decoded command; seq is dropped because it only serves de-duplication
    typedef struct packed {
        logic [3:0]  opcode;
        logic [7:0]  addr;
        logic [15:0] data;
    } cmd_t;

endpackage

// File: rtl/ether_word_edge.sv
// Detects a newly received command word on the frame_ok/frame_data level interface.
module ether_word_edge
    import eth_param_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_ok,
    input  logic [31:0] frame_data,
    output logic        new_word,
    output cmd_t        cmd
);

    logic        prev_ok_q;
    logic [31:0] last_word_q;

    // A word is new on a rising frame_ok or when the good word changes under a held frame_ok
    assign new_word = frame_ok && (!prev_ok_q || (frame_data != last_word_q));

    // Field split of the word being accepted this cycle
    always_comb begin
        cmd.opcode = frame_data[OP_MSB:OP_LSB];
        cmd.addr   = frame_data[ADDR_MSB:ADDR_LSB];
        cmd.data   = frame_data[DATA_MSB:DATA_LSB];
    end

    // Track the previous frame_ok level and the last accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ok_q   <= 1'b0;
            last_word_q <= '0;
        end else begin
            prev_ok_q <= frame_ok;
            if (new_word) begin
                last_word_q <= frame_data;
            end
        end
    end

endmodule

// File: rtl/ether_param_loader.sv
// Decodes register commands into a shadow bank and commits it atomically at frame start.
module ether_param_loader
    import eth_param_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_ok,
    input  logic [31:0]                frame_data,
    input  logic                       frame_start,
    output logic [NUM_REGS*DATA_W-1:0] params,
    output logic                       params_updated,
    output logic                       commit_pending,
    output logic [15:0]                cmd_count,
    output logic [7:0]                 err_count
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic          new_word;
    cmd_t          cmd;
    logic          is_write;
    logic          is_commit;
    logic          is_clear;
    logic          addr_ok;
    logic          cmd_err;
    logic          cmd_good;
    logic          commit_fire;
    commit_state_t state_q;
    commit_state_t state_d;

    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] params_q [NUM_REGS];
    logic              params_updated_q;
    logic [15:0]       cmd_count_q;
    logic [7:0]        err_count_q;

    ether_word_edge u_word_edge (
        .clk        (clk),
        .rst        (rst),
        .frame_ok   (frame_ok),
        .frame_data (frame_data),
        .new_word   (new_word),
        .cmd        (cmd)
    );

    // Command decode and accept/reject classification
    always_comb begin
        is_write    = (cmd.opcode == OP_WRITE);
        is_commit   = (cmd.opcode == OP_COMMIT);
        is_clear    = (cmd.opcode == OP_CLEAR);
        addr_ok     = ({1'b0, cmd.addr} < 9'(NUM_REGS));
        cmd_good    = new_word && ((is_write && addr_ok) || is_commit || is_clear);
        cmd_err     = new_word && !cmd_good;
        commit_fire = (state_q == ARMED) && frame_start;
    end

    // Commit FSM next state; a COMMIT seen while armed changes nothing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (new_word && is_commit) state_d = ARMED;
            ARMED:   if (frame_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Shadow bank writes; the commit copy below samples the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else if (new_word && is_clear) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else if (new_word && is_write && addr_ok) begin
            shadow_q[cmd.addr[AW-1:0]] <= DATA_W'(cmd.data);
        end
    end

    // Active bank copy and its one-cycle update strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) params_q[i] <= '0;
            params_updated_q <= 1'b0;
        end else begin
            if (commit_fire) begin
                for (int i = 0; i < NUM_REGS; i++) params_q[i] <= shadow_q[i];
            end
            params_updated_q <= commit_fire;
        end
    end

    // Accepted commands wrap, rejected commands saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (cmd_good) cmd_count_q <= cmd_count_q + 16'd1;
            if (cmd_err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
        end
    end

    // Flatten the active bank onto the output bus
    always_comb begin
        params = '0;
        for (int i = 0; i < NUM_REGS; i++) params[i*DATA_W +: DATA_W] = params_q[i];
    end

    assign params_updated = params_updated_q;
    assign commit_pending = (state_q == ARMED);
    assign cmd_count      = cmd_count_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_ether_param_loader.sv
// Directed and randomized checks of ether_param_loader against a bank-level model.
module tb_ether_param_loader;

    localparam int unsigned NR = 16;
    localparam int unsigned DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_ok = 1'b0;
    logic [31:0]      frame_data = '0;
    logic             frame_start = 1'b0;
    logic [NR*DW-1:0] params;
    logic             params_updated;
    logic             commit_pending;
    logic [15:0]      cmd_count;
    logic [7:0]       err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_shadow [NR];
    logic [DW-1:0] m_active [NR];
    logic          m_pend, m_upd, m_prev;
    logic [31:0]   m_last;
    logic [15:0]   m_cmd;
    logic [7:0]    m_err;

    ether_param_loader #(.NUM_REGS(NR), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_ok       (frame_ok),
        .frame_data     (frame_data),
        .frame_start    (frame_start),
        .params         (params),
        .params_updated (params_updated),
        .commit_pending (commit_pending),
        .cmd_count      (cmd_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs,
                         input logic [NR*DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_pend = 0; m_upd = 0; m_prev = 0; m_last = '0; m_cmd = '0; m_err = '0;
    endtask

    // One clock of the loader's behaviour, expressed on whole banks and counters
    task automatic model_step(input logic r, input logic ok, input logic [31:0] w,
                              input logic fs);
        logic acc;
        int   op, addr;
        if (r) begin
            model_reset();
            return;
        end
        acc   = ok && (!m_prev || (w != m_last));
        op    = int'(w[31:28]);
        addr  = int'(w[23:16]);
        m_upd = 0;
        if (m_pend && fs) begin
            m_active = m_shadow;
            m_upd    = 1;
            m_pend   = 0;
        end else if (acc && op == 2) begin
            m_pend = 1;
        end
        if (acc) begin
            if ((op == 1 && addr < NR) || op == 2 || op == 3) begin
                m_cmd = m_cmd + 16'd1;
                if (op == 1) m_shadow[addr] = w[15:0];
                if (op == 3) for (int i = 0; i < NR; i++) m_shadow[i] = '0;
            end else if (m_err != 8'hFF) begin
                m_err = m_err + 8'd1;
            end
            m_last = w;
        end
        m_prev = ok;
    endtask

    task automatic check_all();
        logic [NR*DW-1:0] exp_p;
        for (int i = 0; i < NR; i++) exp_p[i*DW +: DW] = m_active[i];
        check("params", params, exp_p);
        check("params_updated", {255'b0, params_updated}, {255'b0, m_upd});
        check("commit_pending", {255'b0, commit_pending}, {255'b0, m_pend});
        check("cmd_count", {240'b0, cmd_count}, {240'b0, m_cmd});
        check("err_count", {248'b0, err_count}, {248'b0, m_err});
    endtask

    // Drive one cycle of inputs, advance model at the edge, compare 1 time unit later
    task automatic step(input logic r, input logic ok, input logic [31:0] w, input logic fs);
        rst = r; frame_ok = ok; frame_data = w; frame_start = fs;
        @(posedge clk);
        model_step(r, ok, w, fs);
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] reg_of(input logic [NR*DW-1:0] p, input int idx);
        return p[idx*DW +: DW];
    endfunction

    initial begin
        logic [15:0] c0;
        logic [31:0] w, prev_w;
        model_reset();
        #1;

        // Reset
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);

        // Write without commit: frame_start must not touch the active bank
        step(0, 1, 32'h1103BEEF, 0);
        step(0, 1, 32'h1103BEEF, 0);
        step(0, 1, 32'h1103BEEF, 1);
        step(0, 1, 32'h1103BEEF, 0);
        check("no_commit_reg3", {240'b0, reg_of(params, 3)}, 256'h0);
        check("cmd_count_1", {240'b0, cmd_count}, 256'd1);

        // Commit then frame_start copies the shadow
        step(0, 1, 32'h22000000, 0);
        check("armed", {255'b0, commit_pending}, 256'd1);
        step(0, 1, 32'h22000000, 1);
        check("reg3_beef", {240'b0, reg_of(params, 3)}, 256'hBEEF);
        check("upd_pulse", {255'b0, params_updated}, 256'd1);
        step(0, 1, 32'h22000000, 0);
        check("upd_one_cycle", {255'b0, params_updated}, 256'd0);
        check("disarmed", {255'b0, commit_pending}, 256'd0);

        // Held word is accepted once; a frame_ok toggle re-accepts it
        c0 = cmd_count;
        for (int i = 0; i < 50; i++) step(0, 1, 32'h11051234, 0);
        check("hold_once", {240'b0, cmd_count}, {240'b0, c0 + 16'd1});
        step(0, 0, 32'h11051234, 0);
        step(0, 1, 32'h11051234, 0);
        check("toggle_again", {240'b0, cmd_count}, {240'b0, c0 + 16'd2});

        // Rejected commands
        c0 = cmd_count;
        step(0, 1, 32'h1320AAAA, 0);
        step(0, 1, 32'h74000000, 0);
        check("err_2", {248'b0, err_count}, 256'd2);
        check("err_no_cmd", {240'b0, cmd_count}, {240'b0, c0});
        for (int i = 0; i < 300; i++) step(0, 1, 32'h70000000 | i, 0);
        check("err_sat", {248'b0, err_count}, 256'hFF);

        // Commit accepted on the same cycle as frame_start from idle only arms
        step(0, 1, 32'h13020011, 0);
        step(0, 1, 32'h25000000, 1);
        check("same_cycle_arm", {255'b0, commit_pending}, 256'd1);
        check("same_cycle_nocopy", {240'b0, reg_of(params, 2)}, 256'h0);
        step(0, 1, 32'h25000000, 0);
        step(0, 1, 32'h25000000, 1);
        check("next_fs_copy", {240'b0, reg_of(params, 2)}, 256'h0011);

        // Write on a committing frame_start lands in shadow only
        step(0, 1, 32'h26000000, 0);
        step(0, 1, 32'h14020042, 1);
        check("pre_write_copy", {240'b0, reg_of(params, 2)}, 256'h0011);
        step(0, 1, 32'h27000000, 0);
        step(0, 1, 32'h27000000, 1);
        check("shadow_got_write", {240'b0, reg_of(params, 2)}, 256'h0042);

        // Randomized traffic
        prev_w = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = prev_w;
            end else begin
                w = {4'($urandom_range(0, 7)), 4'($urandom), 8'($urandom_range(0, 31)),
                     16'($urandom)};
                if ($urandom_range(0, 3) == 0) w[31:28] = 4'h1;
            end
            prev_w = w;
            step(0, $urandom_range(0, 5) != 0, w, $urandom_range(0, 7) == 0);
        end

        // Reset while armed drops the commit
        step(0, 1, 32'h18000000, 0);
        step(0, 1, 32'h29000000, 0);
        check("armed_before_rst", {255'b0, commit_pending}, 256'd1);
        step(1, 1, 32'h29000000, 0);
        check("rst_params", params, 256'h0);
        check("rst_pending", {255'b0, commit_pending}, 256'd0);
        step(0, 0, 32'h0, 1);
        check("rst_no_copy", {255'b0, params_updated}, 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
